// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks:
//   - PARITY_NONE / PARITY_EVEN / PARITY_ODD : parity mode selectors
//   - state_t                                 : receiver FSM encoding (3-bit)
//   - clog2()                                 : ceiling log2, minimum result 1
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter width helper; never returns 0 so a 1-value counter still has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg_if
// Receive-side word interface between uart_rx_cfg and its consumer.
//   o_data       : last received word (LSB = first bit on the line)
//   o_done_data  : one-cycle strobe, o_data and flags valid this cycle
//   o_parity_err : parity mismatch of the flagged frame
//   o_frame_err  : a stop bit was sampled low
//   o_busy       : receiver FSM not in IDLE
//   o_state      : receiver FSM state, for observation only
// Handshake: o_done_data is a valid-only strobe with no ready/back-pressure;
// the consumer must take the word in the cycle the strobe is high. o_data and
// the flags hold their value until the next strobe.
// modport master = receiver (drives), modport slave = consumer (reads).
// ----------------------------------------------------------------------------
interface uart_rx_cfg_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] o_data;
    logic               o_done_data;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_busy;
    state_t             o_state;

    modport master (
        output o_data, o_done_data, o_parity_err, o_frame_err, o_busy, o_state
    );

    modport slave (
        input  o_data, o_done_data, o_parity_err, o_frame_err, o_busy, o_state
    );
endinterface

// File: rtl/uart_bit_sync.sv
// ----------------------------------------------------------------------------
// uart_bit_sync
// NB_SYNC-deep synchronizer for an asynchronous serial line. Resets to 1 so
// an idle-high line never looks like a start bit while leaving reset.
//   i_clk : clock
//   i_rst : asynchronous active-low reset
//   i_bit : asynchronous input
//   o_sb  : synchronized bit, NB_SYNC clocks of latency
// ----------------------------------------------------------------------------
module uart_bit_sync #(
    parameter int NB_SYNC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bit,
    output logic o_sb
);
    logic [NB_SYNC-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_sync <= '1;
        else        r_sync <= {r_sync[NB_SYNC-2:0], i_bit};
    end

    assign o_sb = r_sync[NB_SYNC-1];
endmodule

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver: NB_DATA data bits, optional even/odd parity,
// NB_STOP stop bits, oversampled by NB_TICK ticks per bit.
//   i_clk  : clock          i_rst  : asynchronous active-low reset
//   i_bit  : serial line (idles high, asynchronous)
//   i_tick : one-cycle enable at NB_TICK x baud
//   rx     : uart_rx_cfg_if master (word, done strobe, error flags, busy, state)
// ----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_TICK     = 16,
    parameter int NB_STOP     = 1,
    parameter int PARITY_MODE = 0,
    parameter int NB_SYNC     = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_bit,
    input  logic          i_tick,
    uart_rx_cfg_if.master rx
);
    localparam int TCNT_W = clog2(NB_TICK);
    localparam int BCNT_W = clog2(NB_DATA);
    localparam logic [TCNT_W-1:0] HALF_TICK = TCNT_W'(NB_TICK / 2 - 1);
    localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(NB_TICK - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(NB_DATA - 1);
    localparam logic              LAST_STOP = 1'(NB_STOP - 1);
    localparam logic              HAS_PAR   = (PARITY_MODE != PARITY_NONE);
    localparam logic              ODD_PAR   = (PARITY_MODE == PARITY_ODD);

    logic w_sb;

    uart_bit_sync #(.NB_SYNC(NB_SYNC)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_bit (i_bit),
        .o_sb  (w_sb)
    );

    state_t              r_state, w_next;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [BCNT_W-1:0]   r_bcnt;
    logic                r_scnt;
    logic [NB_DATA-1:0]  r_shreg;
    logic                r_par;
    logic                r_perr;
    logic                r_ferr;
    logic [NB_DATA-1:0]  r_data;
    logic                r_done;
    logic                r_perr_o;
    logic                r_ferr_o;

    // Bit-centre strobes: mid start bit is half a period in, every later
    // sample is a full period after the previous one.
    logic w_mid_start, w_sample, w_state_chg;
    assign w_mid_start = i_tick && (r_tcnt == HALF_TICK);
    assign w_sample    = i_tick && (r_tcnt == LAST_TICK);
    assign w_state_chg = (w_next != r_state);

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_sb) w_next = START;
            // A high line at mid start bit is a glitch, not a frame.
            START:   if (w_mid_start) w_next = w_sb ? IDLE : DATA;
            DATA:    if (w_sample && (r_bcnt == LAST_BIT)) w_next = HAS_PAR ? PARITY : STOP;
            PARITY:  if (w_sample) w_next = STOP;
            STOP:    if (w_sample && (r_scnt == LAST_STOP)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rx.o_busy       = (r_state != IDLE);
        rx.o_state      = r_state;
        rx.o_data       = r_data;
        rx.o_done_data  = r_done;
        rx.o_parity_err = r_perr_o;
        rx.o_frame_err  = r_ferr_o;
    end

    // Datapath: counters, shift register, parity/frame tracking, held outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tcnt   <= '0;
            r_bcnt   <= '0;
            r_scnt   <= 1'b0;
            r_shreg  <= '0;
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A tick coinciding with a transition is absorbed by the restart.
            if (w_state_chg)                   r_tcnt <= '0;
            else if (r_state != IDLE && i_tick) r_tcnt <= w_sample ? '0 : r_tcnt + 1'b1;

            if (w_state_chg)                   r_bcnt <= '0;
            else if (r_state == DATA && w_sample) r_bcnt <= r_bcnt + 1'b1;

            if (w_state_chg)                   r_scnt <= 1'b0;
            else if (r_state == STOP && w_sample) r_scnt <= r_scnt + 1'b1;

            case (r_state)
                IDLE: begin
                    r_par  <= 1'b0;
                    r_perr <= 1'b0;
                    r_ferr <= 1'b0;
                end
                DATA: if (w_sample) begin
                    r_shreg <= {w_sb, r_shreg[NB_DATA-1:1]};
                    r_par   <= r_par ^ w_sb;
                end
                PARITY: if (w_sample) r_perr <= ((r_par ^ w_sb) != ODD_PAR);
                STOP: if (w_sample) begin
                    if (!w_sb) r_ferr <= 1'b1;
                    if (r_scnt == LAST_STOP) begin
                        r_data   <= r_shreg;
                        r_perr_o <= HAS_PAR & r_perr;
                        r_ferr_o <= r_ferr | ~w_sb;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg
// Three receiver configurations on one shared serial line and tick:
//   u0 : 8N1 (defaults), u1 : 8E1, u2 : 7 data, odd parity, 2 stop bits.
// Tick every 2 clocks, 16 ticks per bit -> 32 clocks per bit.
// ----------------------------------------------------------------------------
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT_CLKS = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic r_line = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(negedge clk) tick = ~tick;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg_if #(.NB_DATA(8)) if0 ();
    uart_rx_cfg_if #(.NB_DATA(8)) if1 ();
    uart_rx_cfg_if #(.NB_DATA(7)) if2 ();

    uart_rx_cfg u0 (.i_clk(clk), .i_rst(rst_n), .i_bit(r_line), .i_tick(tick), .rx(if0));

    uart_rx_cfg #(.PARITY_MODE(1)) u1 (
        .i_clk(clk), .i_rst(rst_n), .i_bit(r_line), .i_tick(tick), .rx(if1));

    uart_rx_cfg #(.NB_DATA(7), .PARITY_MODE(2), .NB_STOP(2)) u2 (
        .i_clk(clk), .i_rst(rst_n), .i_bit(r_line), .i_tick(tick), .rx(if2));

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] got_q0[$];
    int         cyc_q0[$];
    logic [7:0] got_q1[$];
    logic [6:0] got_q2[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (if0.o_done_data) begin
            got_q0.push_back(if0.o_data);
            cyc_q0.push_back(cyc);
        end
        if (if1.o_done_data) got_q1.push_back(if1.o_data);
        if (if2.o_done_data) got_q2.push_back(if2.o_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks (called aligned to a falling edge)
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            r_line = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        r_line = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'h3F, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8p1(input logic [7:0] d, input logic p);
        return {5'h1F, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7p2(input logic [6:0] d, input logic p, input logic s2);
        return {5'h1F, s2, 1'b1, p, d, 1'b0};
    endfunction

    int c0;
    int lat;

    initial begin
        // reset state
        repeat (5) @(negedge clk);
        check("rst_data",  if0.o_data, 8'h00);
        check("rst_done",  if0.o_done_data, 1'b0);
        check("rst_perr",  if0.o_parity_err, 1'b0);
        check("rst_ferr",  if0.o_frame_err, 1'b0);
        check("rst_busy",  if0.o_busy, 1'b0);
        check("rst_state", if2.o_state, IDLE);
        rst_n = 1'b1;
        idle_bits(2);

        // 8N1 0xA5 with latency
        got_q0.delete(); cyc_q0.delete();
        c0 = cyc;
        send_bits(f8n1(8'hA5), 10);
        check("a5_ndone", got_q0.size(), 1);
        if (got_q0.size() > 0) begin
            check("a5_data", got_q0[0], 8'hA5);
            lat = cyc_q0[0] - c0;
            check("a5_lat_window", (lat >= 300 && lat <= 315), 1'b1);
        end
        check("a5_perr", if0.o_parity_err, 1'b0);
        check("a5_ferr", if0.o_frame_err, 1'b0);
        check("a5_busy_end", if0.o_busy, 1'b0);
        idle_bits(12);

        // 8E1 0x96: four ones, parity 0 is correct, parity 1 is wrong
        got_q1.delete();
        send_bits(f8p1(8'h96, 1'b0), 11);
        check("e96_ndone", got_q1.size(), 1);
        check("e96_data", if1.o_data, 8'h96);
        check("e96_perr", if1.o_parity_err, 1'b0);
        check("e96_ferr", if1.o_frame_err, 1'b0);
        idle_bits(12);
        got_q1.delete();
        send_bits(f8p1(8'h96, 1'b1), 11);
        check("e96b_ndone", got_q1.size(), 1);
        check("e96b_data", if1.o_data, 8'h96);
        check("e96b_perr", if1.o_parity_err, 1'b1);
        idle_bits(12);

        // 7O2 0x41: two ones, odd parity bit 1; second stop bit low
        got_q2.delete();
        send_bits(f7p2(7'h41, 1'b1, 1'b0), 12);
        check("o41_ndone", got_q2.size(), 1);
        check("o41_data", if2.o_data, 7'h41);
        check("o41_perr", if2.o_parity_err, 1'b0);
        check("o41_ferr", if2.o_frame_err, 1'b1);
        idle_bits(12);

        // glitch of 4 ticks, then a real frame
        got_q0.delete();
        r_line = 1'b0;
        repeat (6) @(negedge clk);
        check("gl_busy_hi", if0.o_busy, 1'b1);
        repeat (2) @(negedge clk);
        r_line = 1'b1;
        repeat (60) @(negedge clk);
        check("gl_busy_lo", if0.o_busy, 1'b0);
        check("gl_ndone", got_q0.size(), 0);
        send_bits(f8n1(8'h3C), 10);
        check("3c_ndone", got_q0.size(), 1);
        check("3c_data", if0.o_data, 8'h3C);
        idle_bits(12);

        // back-to-back 0x11, 0xEE
        got_q0.delete(); cyc_q0.delete();
        exp_q = '{8'h11, 8'hEE};
        send_bits(f8n1(8'h11), 10);
        send_bits(f8n1(8'hEE), 10);
        check("b2b_ndone", got_q0.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q0.size(); i++)
            check($sformatf("b2b_data%0d", i), got_q0[i], exp_q[i]);
        if (cyc_q0.size() == 2)
            check("b2b_spacing", cyc_q0[1] - cyc_q0[0], 10 * BIT_CLKS);
        idle_bits(12);

        // reset in mid DATA of 0x55, held until the stop bit
        got_q0.delete();
        fork
            send_bits(f8n1(8'h55), 10);
            begin
                repeat (144) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("mr_data", if0.o_data, 8'h00);
                check("mr_done", if0.o_done_data, 1'b0);
                check("mr_perr", if0.o_parity_err, 1'b0);
                check("mr_ferr", if0.o_frame_err, 1'b0);
                check("mr_busy", if0.o_busy, 1'b0);
                repeat (157) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle_bits(4);
        check("mr_ndone", got_q0.size(), 0);
        send_bits(f8n1(8'h0F), 10);
        check("0f_ndone", got_q0.size(), 1);
        check("0f_data", if0.o_data, 8'h0F);
        idle_bits(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver. It succeeds the fixed 8N1 receiver and adds configurable data width, optional parity, 1 or 2 stop bits, an input synchronizer, false-start rejection, and error flags.
- Sits between the pad-side serial input and the UART interface/FIFO logic.
- Consumes the shared oversampling tick from the baud-rate generator.
- Delivers one parallel word per frame, with a one-cycle done strobe.

Parameters:
- NB_DATA, 8: data bits per frame; legal 5..9.
- NB_TICK, 16: i_tick pulses per bit period; even, >=4.
- NB_STOP, 1: stop bits; legal 1 or 2.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- NB_SYNC, 2: synchronizer flops on i_bit; >=2.

Ports:
- i_clk, in, 1: system clock; all state on rising edge.
- i_rst, in, 1: asynchronous active-low reset.
- i_bit, in, 1: serial line; idles high; asynchronous to i_clk.
- i_tick, in, 1: one-cycle enable at NB_TICK x baud.
- o_data, out, NB_DATA: last received word, LSB = first bit received.
- o_done_data, out, 1: one-cycle pulse; o_data and the error flags are valid this cycle.
- o_parity_err, out, 1: parity mismatch for the frame flagged by o_done_data.
- o_frame_err, out, 1: a stop bit was sampled low.
- o_busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - FSM goes to IDLE; all counters clear; synchronizer chain loads 1.
  - o_data=0, o_done_data=0, o_parity_err=0, o_frame_err=0, o_busy=0.
  - Reset mid-frame aborts the frame; no done pulse is issued for it.
- Synchronizer: i_bit passes through NB_SYNC flops. All FSM logic uses the synchronized bit (sb). Latency is NB_SYNC clocks.
- Tick counter tcnt: width clog2(NB_TICK). It advances only on i_tick=1 and clears on every state change.
- IDLE:
  - On sb=0, go to START with tcnt=0.
  - i_tick is ignored while in IDLE.
- START:
  - When tcnt reaches NB_TICK/2-1 on a tick (mid start bit): if sb=0, clear tcnt and go to DATA; if sb=1, treat it as a glitch and return to IDLE with no outputs changed.
- DATA:
  - Sample sb every NB_TICK ticks, i.e. when tcnt = NB_TICK-1 on a tick.
  - Shift right into the shift register: new bit enters the MSB; the first bit received ends at the LSB.
  - Bit counter width clog2(NB_DATA). After NB_DATA samples: go to PARITY if PARITY_MODE != 0, else go to STOP.
  - Running parity = XOR of all sampled data bits.
- PARITY:
  - One sample taken at the bit centre.
  - perr = (running XOR ^ sampled bit) != (PARITY_MODE==2).
  - Result: even mode requires the total count of ones to be even; odd mode requires it to be odd.
- STOP:
  - NB_STOP samples, each at a bit centre.
  - ferr is set if any stop sample = 0.
  - After the last stop sample, in the same clock:
    - o_data <= shift register;
    - o_parity_err <= perr (forced 0 when PARITY_MODE=0);
    - o_frame_err <= ferr;
    - o_done_data = 1 for exactly one clock;
    - go to IDLE.
  - Done fires at mid last stop bit. This allows back-to-back frames with no idle gap.
- Holding: o_data, o_parity_err and o_frame_err hold until the next done pulse. They are not cleared on idle.
- Frame-error line: if the line is still low when the FSM returns to IDLE, it re-enters START on the same low level. The glitch-reject test then returns it to IDLE unless a genuine start bit occurs.
- Breaks: no separate break output; a break appears as data=0 with o_frame_err=1.
- Simultaneous events: reset dominates everything. i_tick in the same cycle as a state transition is consumed by the transition (tcnt restarts at 0).
- Data width: NB_DATA=9 with PARITY_MODE=0 is legal. NB_DATA=9 with parity gives a 12-bit frame, which is also legal.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/PARITY_EVEN/PARITY_ODD constants;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - clog2 helper function.
- Sub-module uart_bit_sync: NB_SYNC-deep synchronizer with reset value 1, reused later by the TX/CTS path.

Test Plan:
- Default params, tick every 2 clocks (32 clocks/bit); send 8N1 frame with data 0xA5 -> one o_done_data pulse ~ (9.5 x 32 + NB_SYNC) clocks after start edge; o_data=0xA5; both error flags 0.
- PARITY_MODE=1, send 0x96 with parity bit 0 -> o_data=0x96, perr=0. Then send 0x96 with parity bit 1 -> perr=1, o_data=0x96.
- NB_DATA=7, PARITY_MODE=2, NB_STOP=2; send 0x41 with parity 1 and second stop bit driven 0 -> o_data=0x41, perr=0, ferr=1.
- Line low pulse of 4 ticks (< NB_TICK/2) -> FSM returns to IDLE, no done pulse, o_busy drops. Then send a valid frame 0x3C -> o_data=0x3C.
- Two back-to-back frames 0x11 then 0xEE with no idle gap -> two done pulses 10 bit-periods apart, values in order.
- Assert i_rst low mid-DATA of frame 0x55, release, send 0x0F -> all outputs 0 during reset; no done for 0x55; next done gives o_data=0x0F.
